// File: rtl/pipeline_hazard_unit_pkg.sv
// hazard_pkg: shared types and helpers for the pipeline hazard unit.
package hazard_pkg;
  localparam int TAG_AW = 8;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEMWB = 2'b01, FWD_EXMEM = 2'b10} fwd_sel_e;
  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic [TAG_AW-1:0] rs1;
    logic [TAG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } tag_entry_t;
  function automatic logic producer(tag_entry_t s, logic [TAG_AW-1:0] r, logic x0_zero);
    return s.valid & s.regwrite & (s.rd == r) & !(x0_zero & (r == '0));
  endfunction
  function automatic fwd_sel_e fwd_select(tag_entry_t m, tag_entry_t w, logic [TAG_AW-1:0] r, logic x0_zero);
    return (producer(m, r, x0_zero) & !m.memread) ? FWD_EXMEM : producer(w, r, x0_zero) ? FWD_MEMWB : FWD_RF;
  endfunction
endpackage

// File: rtl/pipeline_hazard_unit_sat_counter.sv
// sat_counter: counter that sticks at its all-ones value.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk)
    if (clear) count <= '0;
    else if (inc & ~&count) count <= count + 1'b1;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: stall/flush/forwarding control from a shadow tag pipeline.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int FWD_EN  = 1,
  parameter int CNT_W   = 32,
  parameter int X0_ZERO = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              branch_taken,
  output logic              pc_hold,
  output logic              ifid_hold,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              exmem_flush,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  localparam logic X0 = (X0_ZERO != 0);
  localparam logic FWD = (FWD_EN != 0);
  tag_entry_t ex, mem, wb, id_e;
  logic [TAG_AW-1:0] r1, r2;
  logic u1, u2, load_use, any_raw, br, stall;
  assign r1 = TAG_AW'(id_rs1);
  assign r2 = TAG_AW'(id_rs2);
  assign u1 = id_valid & id_use_rs1;
  assign u2 = id_valid & id_use_rs2;
  assign id_e = '{valid: 1'b1, rd: TAG_AW'(id_rd), regwrite: id_regwrite, memread: id_memread,
                  rs1: r1, rs2: r2, use_rs1: id_use_rs1, use_rs2: id_use_rs2};
  assign load_use = ex.memread & ((u1 & producer(ex, r1, X0)) | (u2 & producer(ex, r2, X0)));
  assign any_raw = (u1 & (producer(ex, r1, X0) | producer(mem, r1, X0) | producer(wb, r1, X0)))
                 | (u2 & (producer(ex, r2, X0) | producer(mem, r2, X0) | producer(wb, r2, X0)));
  // a taken branch squashes the stalled instruction anyway, so it overrides the stall
  assign br = branch_taken & !reset;
  assign stall = (FWD ? load_use : any_raw) & !branch_taken & !reset;
  assign pc_hold = stall;
  assign ifid_hold = stall;
  assign ifid_flush = br;
  assign idex_bubble = stall | br;
  assign exmem_flush = br;
  assign fwd_a = (!FWD || reset) ? FWD_RF : fwd_select(mem, wb, ex.rs1, X0);
  assign fwd_b = (!FWD || reset) ? FWD_RF : fwd_select(mem, wb, ex.rs2, X0);
  always_ff @(posedge clk)
    if (reset) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      wb  <= mem;
      mem <= exmem_flush ? '0 : ex;
      ex  <= (idex_bubble | !id_valid) ? '0 : id_e;
    end
  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .clear(reset), .inc(pc_hold), .count(stall_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .clear(reset), .inc(br), .count(flush_cnt));
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb_pipeline_hazard_unit: three configurations driven in parallel and checked against a stage-list model.
module tb_pipeline_hazard_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0, id_regwrite = 0, id_memread = 0, branch_taken = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [2:0] ph, ih, ifl, ib, ef;
  logic [2:0][1:0] fa, fb;
  logic [31:0] sc [3];
  logic [31:0] fc [3];
  logic [31:0] sc0, fc0, sc1, fc1;
  logic [3:0] sc2, fc2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  // instance 0: forwarding; 1: stall-only; 2: forwarding with 4-bit counters
  pipeline_hazard_unit #(.FWD_EN(1), .CNT_W(32)) u_f (.clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .pc_hold(ph[0]), .ifid_hold(ih[0]), .ifid_flush(ifl[0]), .idex_bubble(ib[0]), .exmem_flush(ef[0]),
    .fwd_a(fa[0]), .fwd_b(fb[0]), .stall_cnt(sc0), .flush_cnt(fc0));
  pipeline_hazard_unit #(.FWD_EN(0), .CNT_W(32)) u_s (.clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .pc_hold(ph[1]), .ifid_hold(ih[1]), .ifid_flush(ifl[1]), .idex_bubble(ib[1]), .exmem_flush(ef[1]),
    .fwd_a(fa[1]), .fwd_b(fb[1]), .stall_cnt(sc1), .flush_cnt(fc1));
  pipeline_hazard_unit #(.FWD_EN(1), .CNT_W(4)) u_c (.clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .branch_taken(branch_taken),
    .pc_hold(ph[2]), .ifid_hold(ih[2]), .ifid_flush(ifl[2]), .idex_bubble(ib[2]), .exmem_flush(ef[2]),
    .fwd_a(fa[2]), .fwd_b(fb[2]), .stall_cnt(sc2), .flush_cnt(fc2));

  assign sc[0] = sc0;
  assign fc[0] = fc0;
  assign sc[1] = sc1;
  assign fc[1] = fc1;
  assign sc[2] = {28'd0, sc2};
  assign fc[2] = {28'd0, fc2};

  typedef struct {bit v; int rd; bit rw; bit mr; int rs1; int rs2; bit u1; bit u2;} ins_t;
  ins_t pipe [3][3];
  longint scnt [3], fcnt [3];
  int fwd_en [3] = '{1, 0, 1};
  longint cmax [3] = '{64'hffff_ffff, 64'hffff_ffff, 15};

  function automatic bit prod(ins_t e, int r);
    return e.v && e.rw && e.rd == r && r != 0;
  endfunction

  function automatic bit hazard(int k);
    bit h = 0;
    for (int s = 0; s < 3; s++) begin
      if (id_valid && id_use_rs1 && prod(pipe[k][s], int'(id_rs1)) && (fwd_en[k] == 0 || (s == 0 && pipe[k][0].mr))) h = 1;
      if (id_valid && id_use_rs2 && prod(pipe[k][s], int'(id_rs2)) && (fwd_en[k] == 0 || (s == 0 && pipe[k][0].mr))) h = 1;
    end
    return h;
  endfunction

  function automatic int fsel(int k, int r);
    if (fwd_en[k] == 0) return 0;
    if (prod(pipe[k][1], r) && !pipe[k][1].mr) return 2;
    if (prod(pipe[k][2], r)) return 1;
    return 0;
  endfunction

  function automatic logic [8:0] exp_ctl(int k);
    bit st, br;
    logic [1:0] a, b;
    if (reset) return '0;
    br = branch_taken;
    st = hazard(k) && !br;
    a = 2'(fsel(k, pipe[k][0].rs1));
    b = 2'(fsel(k, pipe[k][0].rs2));
    return {st, st, br, st || br, br, a, b};
  endfunction

  function automatic logic [8:0] obs_ctl(int k);
    return {ph[k], ih[k], ifl[k], ib[k], ef[k], fa[k], fb[k]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic update();
    ins_t empty, cur;
    bit st, br;
    empty = '{default: 0};
    cur = '{v: 1, rd: int'(id_rd), rw: id_regwrite, mr: id_memread, rs1: int'(id_rs1), rs2: int'(id_rs2),
            u1: id_use_rs1, u2: id_use_rs2};
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        for (int s = 0; s < 3; s++) pipe[k][s] = empty;
        scnt[k] = 0;
        fcnt[k] = 0;
      end else begin
        br = branch_taken;
        st = hazard(k) && !br;
        if (st && scnt[k] < cmax[k]) scnt[k]++;
        if (br && fcnt[k] < cmax[k]) fcnt[k]++;
        pipe[k][2] = pipe[k][1];
        pipe[k][1] = br ? empty : pipe[k][0];
        pipe[k][0] = (st || br || !id_valid) ? empty : cur;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("model_ctl[%0d]", k), 64'(obs_ctl(k)), 64'(exp_ctl(k)));
      chk($sformatf("model_stall_cnt[%0d]", k), 64'(sc[k]), 64'(scnt[k]));
      chk($sformatf("model_flush_cnt[%0d]", k), 64'(fc[k]), 64'(fcnt[k]));
    end
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic id(int rd, int rs1, int rs2, bit u1, bit u2, bit rw, bit mr);
    id_valid = 1; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_use_rs1 = u1; id_use_rs2 = u2; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    id_valid = 0; id_rd = 0; id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_regwrite = 0; id_memread = 0;
  endtask

  task automatic do_reset();
    nop();
    branch_taken = 0;
    reset = 1;
    step();
    reset = 0;
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      scnt[k] = 0;
      fcnt[k] = 0;
      for (int s = 0; s < 3; s++) pipe[k][s] = '{default: 0};
    end
    #1;
    do_reset();
    #2;
    for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs[%0d]", k), {obs_ctl(k), sc[k], fc[k]}, '0);
    // forwarding EX/MEM -> EX, no stall
    id(5, 1, 2, 1, 1, 1, 0);
    step();
    id(6, 5, 1, 1, 1, 1, 0);
    #2 chk("t1_no_stall", ph[0], 0);
    step();
    nop();
    #2 chk("t1_fwd_a", fa[0], 2'b10);
    chk("t1_fwd_b", fb[0], 2'b00);
    step(); step(); step();
    chk("t1_stall_cnt", sc[0], 0);
    // load-use: one stall then MEM/WB forward
    do_reset();
    id(7, 1, 0, 1, 0, 1, 1);
    step();
    id(8, 7, 7, 1, 1, 1, 0);
    #2 chk("t2_pc_hold", ph[0], 1);
    chk("t2_idex_bubble", ib[0], 1);
    step();
    #2 chk("t2_released", ph[0], 0);
    step();
    nop();
    #2 chk("t2_fwd_a", fa[0], 2'b01);
    chk("t2_fwd_b", fb[0], 2'b01);
    step();
    chk("t2_stall_cnt", sc[0], 1);
    // stall-only RAW
    do_reset();
    id(3, 1, 2, 1, 1, 1, 0);
    step();
    id(4, 3, 2, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("t3_stall_%0d", i), ph[1], 1);
      step();
    end
    #2 chk("t3_released", ph[1], 0);
    step();
    nop();
    for (int i = 0; i < 3; i++) begin
      #2 chk($sformatf("t3_fwd_%0d", i), {fa[1], fb[1]}, 4'b0000);
      step();
    end
    chk("t3_stall_cnt", sc[1], 3);
    // taken branch beats load-use stall
    do_reset();
    id(7, 1, 0, 1, 0, 1, 1);
    step();
    id(8, 7, 7, 1, 1, 1, 0);
    branch_taken = 1;
    #2 chk("t4_flush_triple", {ifl[0], ib[0], ef[0]}, 3'b111);
    chk("t4_no_hold", {ph[0], ih[0]}, 2'b00);
    step();
    branch_taken = 0;
    nop();
    #2 chk("t4_after_fwd", {fa[0], fb[0], ph[0]}, 5'b0);
    step();
    chk("t4_flush_cnt", fc[0], 1);
    chk("t4_stall_cnt", sc[0], 0);
    // x0 is never a producer
    do_reset();
    id(0, 1, 2, 1, 1, 1, 0);
    step();
    id(9, 0, 0, 1, 1, 1, 0);
    #2 chk("t5_no_stall", {ph[0], ph[1]}, 2'b00);
    step();
    nop();
    #2 chk("t5_fwd", {fa[0], fb[0]}, 4'b0000);
    step();
    // saturation of the 4-bit counter, then reset mid-stall
    do_reset();
    id(7, 7, 0, 1, 0, 1, 1);
    for (int i = 0; i < 40; i++) step();
    chk("t6_saturate", sc[2], 15);
    for (int i = 0; i < 4 && !hazard(2); i++) step();
    #2 chk("t6_in_stall", ph[2], 1);
    reset = 1;
    step();
    reset = 0;
    nop();
    #2 for (int k = 0; k < 3; k++) chk($sformatf("t6_reset_outputs[%0d]", k), {obs_ctl(k), sc[k], fc[k]}, '0);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      id_valid = 1'($urandom_range(0, 9) != 0);
      id_rd = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      id_use_rs1 = 1'($urandom);
      id_use_rs2 = 1'($urandom);
      id_regwrite = 1'($urandom_range(0, 3) != 0);
      id_memread = 1'($urandom_range(0, 2) == 0);
      branch_taken = 1'($urandom_range(0, 9) == 0);
      reset = 1'($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;
    branch_taken = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
